scope_dmem_capture: RTL and testbench

SCOPE_DMEM_CAPTURE -- requirements
Module: scope_dmem_capture

---
 rtl/scope_capture_pkg.sv | 53 +++++
 rtl/scope_capture_fifo.sv | 74 +++++++
 rtl/scope_dmem_capture.sv | 161 ++++++++++++++++
 tb/tb_scope_dmem_capture.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_capture_pkg.sv
// Shared definitions for the dmem capture scope.
// Holds field widths, the capture-state encoding and the captured-entry
// layout. Build option: SCOPE_CAPTURE_TIMESTAMP_EN adds a 16-bit cycle
// timestamp as the most significant field of every entry.
package scope_capture_pkg;

  // Widths of the tapped dmem request fields
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TAG_W   = 7;
  localparam int unsigned CMD_W   = 5;
  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned POST_W  = 4;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned TS_W    = 16;

  // Capture-state encoding, also visible on st_state
  typedef enum logic [STATE_W-1:0] {
    STATE_IDLE    = 2'd0,
    STATE_ARMED   = 2'd1,
    STATE_CAPTURE = 2'd2,
    STATE_DONE    = 2'd3
  } scope_state_e;

  // Plain-vector aliases of the state values for the FSM register
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'(STATE_IDLE);
  localparam logic [STATE_W-1:0] ST_ARMED   = 2'(STATE_ARMED);
  localparam logic [STATE_W-1:0] ST_CAPTURE = 2'(STATE_CAPTURE);
  localparam logic [STATE_W-1:0] ST_DONE    = 2'(STATE_DONE);

  // Captured entry, MSB first
`ifdef SCOPE_CAPTURE_TIMESTAMP_EN
  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [TAG_W-1:0]  tag;
    logic [SIZE_W-1:0] size;
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
`else
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [SIZE_W-1:0] size;
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
`endif

  localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage : scope_capture_pkg

// File: rtl/scope_capture_fifo.sv
// Synchronous FIFO holding captured entries.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clear           synchronous flush (pointers and count to zero)
//   push, push_data write request and payload
//   pop             read request, honoured only when not empty
//   head_c          current head, zero when empty
//   valid_c, full_c occupancy flags
//   drop_c          push refused this cycle (full, no same-cycle pop)
//   count           registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module scope_capture_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_c,
  output logic                       valid_c,
  output logic                       full_c,
  output logic                       drop_c,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok_c;
  logic             push_ok_c;

  assign valid_c   = (count_q != '0);
  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign pop_ok_c  = pop & valid_c & ~clear;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok_c = push & ~clear & (~full_c | pop_ok_c);
  assign drop_c    = push & ~clear & full_c & ~pop_ok_c;
  assign head_c    = valid_c ? mem[rd_ptr_q] : '0;
  assign count     = count_q;

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage; never read when empty, so it needs no reset
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= push_data;
  end

endmodule : scope_capture_fifo

// File: rtl/scope_dmem_capture.sv
// Trigger-based capture scope on a core's dmem request channel.
// After an arm pulse the block waits for a request whose address matches
// ctl_trig_addr, stores it plus ctl_post_count following requests into a
// FIFO, then stops. Entries are drained through a valid/ready read port.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   tap_*                       tapped dmem request handshake and fields
//   ctl_arm, ctl_clear          arm pulse, flush pulse (flush wins)
//   ctl_trig_addr               trigger address
//   ctl_post_count              entries kept after the trigger entry
//   rd_valid, rd_ready, rd_entry FIFO head read port
//   st_state, st_count          capture state and FIFO occupancy
//   st_overflow                 sticky flag: an entry was dropped
// Build option: SCOPE_CAPTURE_TIMESTAMP_EN adds a free-running 16-bit cycle
// counter whose value at the event cycle is stored with each entry.
module scope_dmem_capture
  import scope_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tap_valid,
  input  logic                    tap_ready,
  input  logic [ADDR_W-1:0]       tap_addr,
  input  logic [TAG_W-1:0]        tap_tag,
  input  logic [CMD_W-1:0]        tap_cmd,
  input  logic [SIZE_W-1:0]       tap_size,
  input  logic [DATA_W-1:0]       tap_data,
  input  logic                    ctl_arm,
  input  logic                    ctl_clear,
  input  logic [ADDR_W-1:0]       ctl_trig_addr,
  input  logic [POST_W-1:0]       ctl_post_count,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ENTRY_W-1:0]      rd_entry,
  output logic [STATE_W-1:0]      st_state,
  output logic [$clog2(DEPTH):0]  st_count,
  output logic                    st_overflow
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [POST_W-1:0]  remaining_q;
  logic [POST_W-1:0]  remaining_d;
  logic               overflow_q;
  logic               overflow_d;
  logic               push_c;
  logic               drop_c;
  logic               full_c;
  logic               tap_event_c;
  logic               trig_hit_c;
  entry_t             wr_entry_c;

  assign tap_event_c = tap_valid & tap_ready;
  assign trig_hit_c  = tap_event_c & (tap_addr == ctl_trig_addr);

`ifdef SCOPE_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end
`endif

  // Entry assembled from the fields sampled in the event cycle
  always_comb begin
    wr_entry_c      = '0;
`ifdef SCOPE_CAPTURE_TIMESTAMP_EN
    wr_entry_c.ts   = ts_q;
`endif
    wr_entry_c.tag  = tap_tag;
    wr_entry_c.size = tap_size;
    wr_entry_c.cmd  = tap_cmd;
    wr_entry_c.addr = tap_addr;
    wr_entry_c.data = tap_data;
  end

  // FSM and capture-status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next state, remaining count and FIFO write request
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    push_c      = 1'b0;
    if (ctl_clear) begin
      // Flush overrides arm and any same-cycle event
      state_d     = ST_IDLE;
      remaining_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctl_arm) begin
            state_d     = ST_ARMED;
            remaining_d = ctl_post_count;
          end
        end
        ST_ARMED: begin
          if (trig_hit_c) begin
            push_c  = 1'b1;
            state_d = (remaining_q == '0) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // A dropped write (full FIFO) still consumes a post-trigger slot
          if (tap_event_c) begin
            push_c      = 1'b1;
            remaining_d = remaining_q - POST_W'(1);
            if (remaining_q == POST_W'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow, cleared only by a flush
  always_comb begin
    overflow_d = overflow_q | drop_c;
    if (ctl_clear) overflow_d = 1'b0;
  end

  scope_capture_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ctl_clear),
    .push      (push_c),
    .push_data (wr_entry_c),
    .pop       (rd_ready),
    .head_c    (rd_entry),
    .valid_c   (rd_valid),
    .full_c    (full_c),
    .drop_c    (drop_c),
    .count     (st_count)
  );

  assign st_state    = state_q;
  assign st_overflow = overflow_q;

endmodule : scope_dmem_capture

// File: tb/tb_scope_dmem_capture.sv
// Directed and randomized bench for scope_dmem_capture with a queue-based
// reference model of the capture rules.
module tb_scope_dmem_capture;

  localparam int unsigned DEPTH = 8;
`ifdef SCOPE_CAPTURE_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = 94;
`else
  localparam int unsigned ENTRY_W = 78;
`endif

  logic                clk;
  logic                rst_n;
  logic                tap_valid;
  logic                tap_ready;
  logic [31:0]         tap_addr;
  logic [6:0]          tap_tag;
  logic [4:0]          tap_cmd;
  logic [1:0]          tap_size;
  logic [31:0]         tap_data;
  logic                ctl_arm;
  logic                ctl_clear;
  logic [31:0]         ctl_trig_addr;
  logic [3:0]          ctl_post_count;
  logic                rd_valid;
  logic                rd_ready;
  logic [ENTRY_W-1:0]  rd_entry;
  logic [1:0]          st_state;
  logic [3:0]          st_count;
  logic                st_overflow;

  scope_dmem_capture #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tap_valid      (tap_valid),
    .tap_ready      (tap_ready),
    .tap_addr       (tap_addr),
    .tap_tag        (tap_tag),
    .tap_cmd        (tap_cmd),
    .tap_size       (tap_size),
    .tap_data       (tap_data),
    .ctl_arm        (ctl_arm),
    .ctl_clear      (ctl_clear),
    .ctl_trig_addr  (ctl_trig_addr),
    .ctl_post_count (ctl_post_count),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_entry       (rd_entry),
    .st_state       (st_state),
    .st_count       (st_count),
    .st_overflow    (st_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tb_cyc   = 0;

  // Reference model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 done
  int                 m_phase = 0;
  int                 m_left  = 0;
  bit                 m_ovf   = 1'b0;
  logic [ENTRY_W-1:0] exp_q[$];

  logic [31:0] ev027 [5] = '{32'h100, 32'h2000, 32'h104, 32'h108, 32'h10C};
  logic [31:0] ex027 [3] = '{32'h2000, 32'h104, 32'h108};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [ENTRY_W-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("st_state",    128'(st_state),    128'(m_phase));
    chk("st_count",    128'(st_count),    128'(exp_q.size()));
    chk("rd_valid",    128'(rd_valid),    128'(exp_q.size() != 0));
    chk("st_overflow", 128'(st_overflow), 128'(m_ovf));
    chk("rd_entry",    128'(rd_entry),    128'(head));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_phase = 0;
    m_left  = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic idle_in();
    tap_valid = 1'b0;
    tap_ready = 1'b0;
    ctl_arm   = 1'b0;
    ctl_clear = 1'b0;
    rd_ready  = 1'b0;
  endtask

  task automatic set_ev(input logic [31:0] a);
    tap_valid = 1'b1;
    tap_ready = 1'b1;
    tap_addr  = a;
    tap_tag   = 7'($urandom);
    tap_cmd   = 5'($urandom);
    tap_size  = 2'($urandom);
    tap_data  = $urandom;
  endtask

  // Apply current inputs for one clock; model updates, then check at negedge
  task automatic cycle(input bit do_chk = 1'b1);
    bit                 ev;
    bit                 pop;
    bit                 wr;
    logic [ENTRY_W-1:0] e;
    ev  = tap_valid && tap_ready;
    pop = rd_ready && (exp_q.size() != 0);
    wr  = 1'b0;
`ifdef SCOPE_CAPTURE_TIMESTAMP_EN
    e = {16'(tb_cyc), tap_tag, tap_size, tap_cmd, tap_addr, tap_data};
`else
    e = {tap_tag, tap_size, tap_cmd, tap_addr, tap_data};
`endif
    if (ctl_clear) begin
      model_reset();
    end else begin
      if (m_phase == 0 && ctl_arm) begin
        m_phase = 1;
        m_left  = int'(ctl_post_count);
      end else if (m_phase == 1 && ev && tap_addr == ctl_trig_addr) begin
        wr      = 1'b1;
        m_phase = (m_left == 0) ? 3 : 2;
      end else if (m_phase == 2 && ev) begin
        wr     = 1'b1;
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 3;
      end
      if (pop) void'(exp_q.pop_front());
      if (wr) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else                      m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    tb_cyc++;
    @(negedge clk);
    if (do_chk) check_all();
  endtask

  task automatic arm(input logic [31:0] trig, input logic [3:0] post);
    idle_in();
    ctl_clear = 1'b1;
    cycle();
    idle_in();
    ctl_trig_addr  = trig;
    ctl_post_count = post;
    ctl_arm        = 1'b1;
    cycle();
    idle_in();
  endtask

  initial begin
    rst_n          = 1'b0;
    idle_in();
    tap_addr       = '0;
    tap_tag        = '0;
    tap_cmd        = '0;
    tap_size       = '0;
    tap_data       = '0;
    ctl_trig_addr  = '0;
    ctl_post_count = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_all();
    rst_n  = 1'b1;
    tb_cyc = 0;
    cycle();

    // Trigger in the middle of traffic, two post-trigger entries
    arm(32'h2000, 4'd2);
    for (int i = 0; i < 5; i++) begin
      set_ev(ev027[i]);
      cycle();
      idle_in();
    end
    chk("r027_state", 128'(st_state), 128'(3));
    chk("r027_count", 128'(st_count), 128'(3));
    for (int i = 0; i < 3; i++) begin
      chk("r027_addr", 128'(rd_entry[63:32]), 128'(ex027[i]));
      rd_ready = 1'b1;
      cycle();
      idle_in();
    end
    chk("r027_empty", 128'(rd_valid), 128'(0));

    // Zero post-count: only the trigger entry is kept
    arm(32'h40, 4'd0);
    set_ev(32'h40);
    cycle();
    chk("r028_state", 128'(st_state), 128'(3));
    chk("r028_count", 128'(st_count), 128'(1));
    set_ev(32'h44);
    cycle();
    set_ev(32'h40);
    cycle();
    idle_in();
    chk("r028_after", 128'(st_count), 128'(1));
    rd_ready = 1'b1;
    cycle();
    idle_in();

    // Overflow: 16 writes into an 8-deep FIFO with no reads
    arm(32'h3000, 4'd15);
    for (int i = 0; i < 16; i++) begin
      set_ev(32'h3000 + 32'(4 * i));
      cycle();
    end
    set_ev(32'h3000);
    cycle();
    idle_in();
    chk("r029_state", 128'(st_state), 128'(3));
    chk("r029_count", 128'(st_count), 128'(8));
    chk("r029_ovf",   128'(st_overflow), 128'(1));
    for (int i = 0; i < 8; i++) begin
      chk("r029_drain", 128'(rd_entry[63:32]), 128'(32'h3000 + 32'(4 * i)));
      rd_ready = 1'b1;
      cycle();
      idle_in();
    end

    // Full FIFO with push and pop in the same cycle
    arm(32'h5000, 4'd15);
    for (int i = 0; i < 8; i++) begin
      set_ev(32'h5000 + 32'(4 * i));
      cycle();
    end
    set_ev(32'h5020);
    rd_ready = 1'b1;
    cycle();
    idle_in();
    chk("r030_count", 128'(st_count), 128'(8));
    chk("r030_ovf",   128'(st_overflow), 128'(0));
    for (int i = 0; i < 8; i++) begin
      chk("r030_drain", 128'(rd_entry[63:32]), 128'(32'h5004 + 32'(4 * i)));
      rd_ready = 1'b1;
      cycle();
      idle_in();
    end

    // Clear beats arm and a pending event while capturing
    set_ev(32'h6000);
    cycle();
    chk("r031_pre", 128'(st_count), 128'(1));
    set_ev(32'h6004);
    ctl_clear = 1'b1;
    ctl_arm   = 1'b1;
    cycle();
    idle_in();
    chk("r031_state", 128'(st_state), 128'(0));
    chk("r031_count", 128'(st_count), 128'(0));
    chk("r031_valid", 128'(rd_valid), 128'(0));

    // Asynchronous reset in the middle of a capture
    arm(32'h7000, 4'd5);
    set_ev(32'h7000);
    cycle();
    set_ev(32'h7004);
    cycle();
    idle_in();
    rst_n = 1'b0;
    #1;
    chk("rst_state", 128'(st_state), 128'(0));
    chk("rst_count", 128'(st_count), 128'(0));
    chk("rst_valid", 128'(rd_valid), 128'(0));
    chk("rst_ovf",   128'(st_overflow), 128'(0));
    chk("rst_entry", 128'(rd_entry), 128'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    tb_cyc = 0;
    cycle();

    // Randomized traffic: first phase mostly stalled reads, then mostly open
    ctl_trig_addr = 32'h8000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) set_ev(32'h8000);
      else                           set_ev(32'h8000 + 32'(4 * $urandom_range(1, 8)));
      tap_valid      = 1'($urandom_range(0, 1));
      tap_ready      = 1'($urandom_range(0, 1));
      ctl_arm        = ($urandom_range(0, 7) == 0);
      ctl_clear      = ($urandom_range(0, 47) == 0);
      ctl_post_count = 4'($urandom);
      if (i < 300) rd_ready = ($urandom_range(0, 3) == 0);
      else         rd_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_in();

`ifdef SCOPE_CAPTURE_TIMESTAMP_EN
    // Timestamp wrap: trigger at 0xFFFE, next event three cycles later
    arm(32'h9000, 4'd1);
    while (16'(tb_cyc) != 16'hFFFE) cycle(1'b0);
    set_ev(32'h9000);
    cycle();
    idle_in();
    chk("ts_trig", 128'(rd_entry[93:78]), 128'(16'hFFFE));
    cycle();
    cycle();
    set_ev(32'h9004);
    cycle();
    idle_in();
    rd_ready = 1'b1;
    cycle();
    idle_in();
    chk("ts_wrap", 128'(rd_entry[93:78]), 128'(16'h0001));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_scope_dmem_capture
